// File: rtl/regfile_write_queue.sv
// Write-side front end for the 16x16 register file: buffers ALU and load writebacks
// in a small FIFO, drains one write per cycle and flags reads of still-pending registers.
module regfile_write_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Alu_Valid,
   output logic             Alu_Ready,
   input  logic [3:0]       Alu_Reg,
   input  logic [15:0]      Alu_Data,
   input  logic             Mem_Valid,
   output logic             Mem_Ready,
   input  logic [3:0]       Mem_Reg,
   input  logic [15:0]      Mem_Data,
   output logic [3:0]       Reg_Write,
   output logic             Write_Enable,
   output logic [15:0]      Write_Data,
   input  logic [3:0]       Query_A,
   input  logic [3:0]       Query_B,
   output logic             Hazard_A,
   output logic             Hazard_B,
   output logic [PTR_W:0]   Count
);

   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ZERO_C  = (PTR_W+1)'(0);
   localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   TWO_C   = (PTR_W+1)'(2);

   logic [3:0]          reg_q_r  [DEPTH];
   logic [15:0]         data_q_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [PTR_W:0]      count_r;

   logic [PTR_W:0]      free_s;
   logic                alu_ready_s;
   logic                mem_ready_s;
   logic                alu_push_s;
   logic                mem_push_s;
   logic                pop_s;
   logic [PTR_W:0]      push_cnt_s;
   logic [PTR_W-1:0]    mem_ptr_s;
   logic [PTR_W-1:0]    offset_s;
   logic [DEPTH-1:0]    occ_s;
   logic                hazard_a_s;
   logic                hazard_b_s;

   // Acceptance and pop decisions, all based on occupancy at the start of the cycle
   always_comb begin
      free_s      = DEPTH_C - count_r;
      mem_ready_s = (free_s >= ONE_C);
      // Loads take priority for the last free slot
      alu_ready_s = (free_s >= TWO_C) || ((free_s == ONE_C) && !Mem_Valid);
      alu_push_s  = Alu_Valid & alu_ready_s;
      mem_push_s  = Mem_Valid & mem_ready_s;
      pop_s       = (count_r != ZERO_C);
      push_cnt_s  = (PTR_W+1)'(alu_push_s) + (PTR_W+1)'(mem_push_s);
      mem_ptr_s   = wr_ptr_r + PTR_W'(alu_push_s);
   end

   assign Alu_Ready = alu_ready_s;
   assign Mem_Ready = mem_ready_s;
   assign Count     = count_r;

   // FIFO storage: ALU entry at the write pointer, load entry right behind it
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_q_r[i]  <= 4'h0;
            data_q_r[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_push_s && (wr_ptr_r == PTR_W'(i))) begin
               reg_q_r[i]  <= Alu_Reg;
               data_q_r[i] <= Alu_Data;
            end else if (mem_push_s && (mem_ptr_s == PTR_W'(i))) begin
               reg_q_r[i]  <= Mem_Reg;
               data_q_r[i] <= Mem_Data;
            end
         end
      end
   end

   // Pointers and occupancy; full/empty comes from the count, never pointer equality
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= ZERO_C;
      end else begin
         wr_ptr_r <= wr_ptr_r + push_cnt_s[PTR_W-1:0];
         rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
         count_r  <= count_r + push_cnt_s - (PTR_W+1)'(pop_s);
      end
   end

   // Register-file write port; select and data hold when nothing drains
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Write_Enable <= 1'b0;
         Reg_Write    <= 4'h0;
         Write_Data   <= 16'h0000;
      end else if (pop_s) begin
         Write_Enable <= 1'b1;
         Reg_Write    <= reg_q_r[rd_ptr_r];
         Write_Data   <= data_q_r[rd_ptr_r];
      end else begin
         Write_Enable <= 1'b0;
      end
   end

   // Pending-write lookup over occupied entries plus the write port itself
   always_comb begin
      occ_s      = {DEPTH{1'b0}};
      offset_s   = {PTR_W{1'b0}};
      hazard_a_s = 1'b0;
      hazard_b_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offset_s   = PTR_W'(i) - rd_ptr_r;
         occ_s[i]   = ({1'b0, offset_s} < count_r);
         hazard_a_s = hazard_a_s | (occ_s[i] & (reg_q_r[i] == Query_A));
         hazard_b_s = hazard_b_s | (occ_s[i] & (reg_q_r[i] == Query_B));
      end
      hazard_a_s = hazard_a_s | (Write_Enable & (Reg_Write == Query_A));
      hazard_b_s = hazard_b_s | (Write_Enable & (Reg_Write == Query_B));
   end

   assign Hazard_A = Reset_n & hazard_a_s;
   assign Hazard_B = Reset_n & hazard_b_s;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_regfile_write_queue;

   logic          Clk;
   logic          Reset_n;
   logic          Alu_Valid;
   logic          Alu_Ready;
   logic [3:0]    Alu_Reg;
   logic [15:0]   Alu_Data;
   logic          Mem_Valid;
   logic          Mem_Ready;
   logic [3:0]    Mem_Reg;
   logic [15:0]   Mem_Data;
   logic [3:0]    Reg_Write;
   logic          Write_Enable;
   logic [15:0]   Write_Data;
   logic [3:0]    Query_A;
   logic [3:0]    Query_B;
   logic          Hazard_A;
   logic          Hazard_B;
   logic [2:0]    Count;

   regfile_write_queue #(.DEPTH(4), .PTR_W(2)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Reg(Alu_Reg), .Alu_Data(Alu_Data),
      .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready), .Mem_Reg(Mem_Reg), .Mem_Data(Mem_Data),
      .Reg_Write(Reg_Write), .Write_Enable(Write_Enable), .Write_Data(Write_Data),
      .Query_A(Query_A), .Query_B(Query_B), .Hazard_A(Hazard_A), .Hazard_B(Hazard_B),
      .Count(Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int            n_checks = 0;
   int            n_fail   = 0;

   // Reference model: pending writes in acceptance order, plus the write port state
   logic [19:0]   model_q[$];
   logic          exp_we   = 1'b0;
   logic [3:0]    exp_reg  = 4'h0;
   logic [15:0]   exp_data = 16'h0000;
   int            issued[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_hazard(input logic [3:0] r);
      logic h;
      h = exp_we && (exp_reg == r);
      foreach (model_q[i]) begin
         if (model_q[i][19:16] == r) h = 1'b1;
      end
      return h;
   endfunction

   // One clock cycle: drive, check readiness/hazards, advance model, check write port
   task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic mv, input logic [3:0] mr, input logic [15:0] md,
                       input logic [3:0] qa, input logic [3:0] qb);
      int          free;
      logic        ea;
      logic        em;
      logic [19:0] e;
      @(negedge Clk);
      Alu_Valid = av; Alu_Reg = ar; Alu_Data = ad;
      Mem_Valid = mv; Mem_Reg = mr; Mem_Data = md;
      Query_A   = qa; Query_B = qb;
      #1;
      free = 4 - model_q.size();
      em   = (free >= 1);
      ea   = (free >= 2) || ((free == 1) && !mv);
      check_eq("mem_ready", Mem_Ready, em);
      check_eq("alu_ready", Alu_Ready, ea);
      check_eq("hazard_a", Hazard_A, model_hazard(qa));
      check_eq("hazard_b", Hazard_B, model_hazard(qb));
      @(posedge Clk);
      if (model_q.size() > 0) begin
         e        = model_q.pop_front();
         exp_we   = 1'b1;
         exp_reg  = e[19:16];
         exp_data = e[15:0];
      end else begin
         exp_we   = 1'b0;
      end
      if (av && ea) model_q.push_back({ar, ad});
      if (mv && em) model_q.push_back({mr, md});
      #1;
      check_eq("write_enable", Write_Enable, exp_we);
      check_eq("reg_write", Reg_Write, exp_reg);
      check_eq("write_data", Write_Data, exp_data);
      check_eq("count", Count, model_q.size());
      if (Write_Enable) issued.push_back(int'(Reg_Write));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, Query_A, Query_B);
   endtask

   initial begin
      Reset_n   = 1'b0;
      Alu_Valid = 1'b0; Alu_Reg = 4'h0; Alu_Data = 16'h0000;
      Mem_Valid = 1'b0; Mem_Reg = 4'h0; Mem_Data = 16'h0000;
      Query_A   = 4'h0; Query_B = 4'h0;
      #12;
      check_eq("rst_we", Write_Enable, 1'b0);
      check_eq("rst_count", Count, 3'd0);
      check_eq("rst_reg", Reg_Write, 4'h0);
      check_eq("rst_data", Write_Data, 16'h0000);
      check_eq("rst_haz_a", Hazard_A, 1'b0);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Single ALU push: issues two edges later, gone one edge after that
      step(1'b1, 4'd3, 16'h1234, 1'b0, 4'h0, 16'h0000, 4'h0, 4'h0);
      check_eq("t1_we_early", Write_Enable, 1'b0);
      idle(1);
      check_eq("t1_we", Write_Enable, 1'b1);
      check_eq("t1_reg", Reg_Write, 4'd3);
      check_eq("t1_data", Write_Data, 16'h1234);
      idle(1);
      check_eq("t1_we_off", Write_Enable, 1'b0);
      check_eq("t1_count", Count, 3'd0);

      // Simultaneous ALU and load: ALU entry is older
      step(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'h5555, 4'h0, 4'h0);
      check_eq("t2_peak", Count, 3'd2);
      idle(1);
      check_eq("t2_first", Reg_Write, 4'd1);
      idle(1);
      check_eq("t2_second", Reg_Write, 4'd2);
      idle(2);

      // Both producers every cycle: occupancy climbs to 3, then only loads get in
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'(i + 8), 16'(16'h0100 + i), 1'b1, 4'(i + 12), 16'(16'h0200 + i), 4'h0, 4'h0);
      check_eq("t3_count3", Count, 3'd3);
      check_eq("t3_alu_blocked", Alu_Ready, 1'b0);
      idle(5);

      // Hazard tracking for a queued R5
      step(1'b1, 4'd5, 16'h0055, 1'b0, 4'h0, 16'h0000, 4'd5, 4'd6);
      check_eq("t4_haz_queued", Hazard_A, 1'b1);
      check_eq("t4_haz_b", Hazard_B, 1'b0);
      idle(1);
      check_eq("t4_haz_port", Hazard_A, 1'b1);
      idle(1);
      check_eq("t4_haz_clear", Hazard_A, 1'b0);

      // Ten single pushes across pointer wrap
      issued.delete();
      for (int i = 0; i < 10; i++)
         step(1'b1, 4'(i), 16'($urandom), 1'b0, 4'h0, 16'h0000, 4'h0, 4'h0);
      idle(3);
      check_eq("t5_issued_n", issued.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < issued.size()) check_eq("t5_order", issued[i], i);

      // Asynchronous reset with three writes queued
      step(1'b1, 4'd7, 16'h7777, 1'b1, 4'd9, 16'h9999, 4'd7, 4'd9);
      step(1'b1, 4'd10, 16'hAAA0, 1'b1, 4'd11, 16'hBBB0, 4'd7, 4'd9);
      check_eq("t6_count_pre", Count, 3'd3);
      #2;
      Reset_n   = 1'b0;
      Alu_Valid = 1'b0;
      Mem_Valid = 1'b0;
      #1;
      check_eq("t6_we_rst", Write_Enable, 1'b0);
      check_eq("t6_count_rst", Count, 3'd0);
      check_eq("t6_haz_rst", Hazard_A, 1'b0);
      model_q.delete();
      exp_we = 1'b0; exp_reg = 4'h0; exp_data = 16'h0000;
      @(negedge Clk);
      Reset_n = 1'b1;
      issued.delete();
      idle(4);
      check_eq("t6_no_stale", issued.size(), 0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 2) != 0), 4'($urandom), 16'($urandom),
              1'($urandom_range(0, 2) != 0), 4'($urandom), 16'($urandom),
              4'($urandom), 4'($urandom));
      idle(5);
      check_eq("final_count", Count, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
